// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller and its output-logic stage:
// state encodings and the default entry count.
package fifo_pkg;

    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_STATE_W = 3;

    typedef enum logic [FIFO_STATE_W-1:0] {
        ST_INIT     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_RD_ERROR = 3'b100,
        ST_NO_OP    = 3'b111
    } fifo_state_e;

endpackage

// File: rtl/fifo_ns.sv
// Next-state / next-occupancy logic for the FIFO controller.
// The decision depends only on the request pair and the current occupancy,
// never on the current state. Optional macro FIFO_SIMUL_RW_EN lets a
// simultaneous write+read go through instead of being treated as idle.
module fifo_ns
    import fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] data_count,
    output fifo_state_e      next_state,
    output logic [CNT_W-1:0] next_count,
    output logic             do_wr,
    output logic             do_rd
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic is_empty;
    logic is_full;

    assign is_empty = (data_count == '0);
    assign is_full  = (data_count == FULL_CNT);

    // Decode the request pair against occupancy into state, count and access strobes
    always_comb begin
        next_state = ST_NO_OP;
        next_count = data_count;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        unique case ({wr_en, rd_en})
            2'b10: begin
                if (!is_full) begin
                    next_state = ST_WRITE;
                    next_count = data_count + 1'b1;
                    do_wr      = 1'b1;
                end else begin
                    next_state = ST_WR_ERROR;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    next_state = ST_READ;
                    next_count = data_count - 1'b1;
                    do_rd      = 1'b1;
                end else begin
                    next_state = ST_RD_ERROR;
                end
            end
            2'b11: begin
`ifdef FIFO_SIMUL_RW_EN
                // At the boundaries only the legal half of the pair is performed
                if (is_empty) begin
                    next_state = ST_WRITE;
                    next_count = data_count + 1'b1;
                    do_wr      = 1'b1;
                end else if (is_full) begin
                    next_state = ST_READ;
                    next_count = data_count - 1'b1;
                    do_rd      = 1'b1;
                end else begin
                    next_state = ST_NO_OP;
                    do_wr      = 1'b1;
                    do_rd      = 1'b1;
                end
`else
                next_state = ST_NO_OP;
`endif
            end
            default: begin
                next_state = ST_NO_OP;
            end
        endcase
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: holds state, occupancy and head/tail pointers, and drives
// the register-file write/read strobes. Strobes are combinational from the
// requests and the registered occupancy, so an access in a given cycle uses
// the pointer values before that cycle's update.
// Optional macro FIFO_SIMUL_RW_EN enables simultaneous write+read.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [FIFO_STATE_W-1:0] state,
    output logic [CNT_W-1:0]        data_count,
    output logic [PTR_W-1:0]        head,
    output logic [PTR_W-1:0]        tail,
    output logic                    we,
    output logic                    re
);

    fifo_state_e      state_q;
    fifo_state_e      state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic             do_wr;
    logic             do_rd;

    fifo_ns #(
        .DEPTH (DEPTH)
    ) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_count (count_q),
        .next_state (state_d),
        .next_count (count_d),
        .do_wr      (do_wr),
        .do_rd      (do_rd)
    );

    // Pointers advance on an accepted access; power-of-two DEPTH makes the wrap free
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (do_rd) begin
            head_d = head_q + 1'b1;
        end
        if (do_wr) begin
            tail_d = tail_q + 1'b1;
        end
    end

    // Register state, occupancy and pointers; reset clears the FIFO logically
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign we         = do_wr & ~reset;
    assign re         = do_rd & ~reset;
    assign state      = state_q;
    assign data_count = count_q;
    assign head       = head_q;
    assign tail       = tail_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reset, fill, overflow, drain, underflow,
// idle, simultaneous request and reset mid-fill.
module tb_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] state;
    logic [3:0] data_count;
    logic [2:0] head;
    logic [2:0] tail;
    logic       we;
    logic       re;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_ctrl #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .state      (state),
        .data_count (data_count),
        .head       (head),
        .tail       (tail),
        .we         (we),
        .re         (re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from the falling edge, check strobes before the rising
    // edge, then check registered outputs just after it.
    task automatic step(input string tag, input logic rst, input logic w, input logic r,
                        input logic e_we, input logic e_re, input logic [2:0] e_st,
                        input logic [3:0] e_cnt, input logic [2:0] e_hd, input logic [2:0] e_tl);
        @(negedge clk);
        reset = rst;
        wr_en = w;
        rd_en = r;
        #1;
        check({tag, ".we"}, 8'(we), 8'(e_we));
        check({tag, ".re"}, 8'(re), 8'(e_re));
        @(posedge clk);
        #1;
        check({tag, ".state"}, 8'(state), 8'(e_st));
        check({tag, ".count"}, 8'(data_count), 8'(e_cnt));
        check({tag, ".head"}, 8'(head), 8'(e_hd));
        check({tag, ".tail"}, 8'(tail), 8'(e_tl));
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset held two cycles with a write request pending
        step("rst0", 1, 1, 0, 0, 0, 3'b000, 4'd0, 3'd0, 3'd0);
        step("rst1", 1, 1, 0, 0, 0, 3'b000, 4'd0, 3'd0, 3'd0);

        // Fill from empty
        for (int i = 0; i < 8; i++) begin
            step($sformatf("fill%0d", i), 0, 1, 0, 1, 0, 3'b001, 4'(i + 1), 3'd0, 3'(i + 1));
        end
        step("ovf", 0, 1, 0, 0, 0, 3'b011, 4'd8, 3'd0, 3'd0);

        // Drain from full
        for (int i = 0; i < 8; i++) begin
            step($sformatf("drain%0d", i), 0, 0, 1, 0, 1, 3'b010, 4'(7 - i), 3'(i + 1), 3'd0);
        end
        step("udf", 0, 0, 1, 0, 0, 3'b100, 4'd0, 3'd0, 3'd0);

        // Simultaneous request on an empty FIFO
`ifdef FIFO_SIMUL_RW_EN
        step("sim_empty", 0, 1, 1, 1, 0, 3'b001, 4'd1, 3'd0, 3'd1);
        step("sim_fill1", 0, 1, 0, 1, 0, 3'b001, 4'd2, 3'd0, 3'd2);
        step("sim_fill2", 0, 1, 0, 1, 0, 3'b001, 4'd3, 3'd0, 3'd3);
`else
        step("sim_empty", 0, 1, 1, 0, 0, 3'b111, 4'd0, 3'd0, 3'd0);
        step("w3a", 0, 1, 0, 1, 0, 3'b001, 4'd1, 3'd0, 3'd1);
        step("w3b", 0, 1, 0, 1, 0, 3'b001, 4'd2, 3'd0, 3'd2);
        step("w3c", 0, 1, 0, 1, 0, 3'b001, 4'd3, 3'd0, 3'd3);
`endif

        // Idle at count 3
        step("idle", 0, 0, 0, 0, 0, 3'b111, 4'd3, 3'd0, 3'd3);
        step("w4", 0, 1, 0, 1, 0, 3'b001, 4'd4, 3'd0, 3'd4);

        // Simultaneous request at count 4
`ifdef FIFO_SIMUL_RW_EN
        step("sim4", 0, 1, 1, 1, 1, 3'b111, 4'd4, 3'd1, 3'd5);
`else
        step("sim4", 0, 1, 1, 0, 0, 3'b111, 4'd4, 3'd0, 3'd4);
`endif

        // Reset, refill to 5, then reset mid-fill with a write pending
        step("rst2", 1, 0, 0, 0, 0, 3'b000, 4'd0, 3'd0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("refill%0d", i), 0, 1, 0, 1, 0, 3'b001, 4'(i + 1), 3'd0, 3'(i + 1));
        end
        step("rst_mid", 1, 1, 0, 0, 0, 3'b000, 4'd0, 3'd0, 3'd0);
        step("post_rst", 0, 1, 0, 1, 0, 3'b001, 4'd1, 3'd0, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; must be a power of two.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port wr_en  input  1  write request for the current cycle.
REQ-005 SHALL have port rd_en  input  1  read request for the current cycle.
REQ-006 SHALL have port state  output  3  registered FSM state; drives the FIFO output-logic stage.
REQ-007 SHALL have port data_count  output  4  registered occupancy, 0..DEPTH.
REQ-008 SHALL have port head  output  3  registered read pointer into the register file.
REQ-009 SHALL have port tail  output  3  registered write pointer into the register file.
REQ-010 SHALL have port we  output  1  combinational register-file write strobe at address tail.
REQ-011 SHALL have port re  output  1  combinational register-file read strobe at address head.

Function
REQ-012 SHALL encode states INIT=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100, NO_OP=111; other codes unreachable.
REQ-013 SHALL compute the next state each cycle from wr_en, rd_en and the current data_count, independent of current state.
REQ-014 SHALL, on wr_en=1, rd_en=0, data_count<DEPTH: go to WRITE, increment data_count, advance tail, assert we.
REQ-015 SHALL, on wr_en=1, rd_en=0, data_count=DEPTH: go to WR_ERROR, hold data_count, tail and head, keep we=0.
REQ-016 SHALL, on rd_en=1, wr_en=0, data_count>0: go to READ, decrement data_count, advance head, assert re.
REQ-017 SHALL, on rd_en=1, wr_en=0, data_count=0: go to RD_ERROR, hold data_count and pointers, keep re=0.
REQ-018 SHALL, on wr_en=0, rd_en=0: go to NO_OP, hold data_count and pointers, keep we=re=0.
REQ-019 SHALL wrap head and tail modulo DEPTH (7 -> 0); data_count never wraps or saturates past 0/DEPTH.
REQ-020 SHALL derive we and re combinationally from wr_en, rd_en and registered data_count, so the register-file access in a cycle uses the pre-update tail/head.
REQ-021 SHALL present data_count as the post-operation occupancy in the same cycle the corresponding state value appears.

Reset
REQ-022 SHALL, while reset=1 at a clk edge, load state=INIT, data_count=0, head=0, tail=0, regardless of wr_en/rd_en.
REQ-023 SHALL force we=0 and re=0 combinationally while reset=1.
REQ-024 SHALL abandon any in-progress operation on reset mid-stream; contents are discarded logically by pointer clear.

Configuration
REQ-025 SHALL, with FIFO_SIMUL_RW_EN undefined, treat wr_en=rd_en=1 as NO_OP: no pointer or count change, we=re=0.
REQ-026 SHALL, with FIFO_SIMUL_RW_EN defined and 0<data_count<DEPTH, on wr_en=rd_en=1 go to NO_OP, assert we and re, advance both pointers, hold data_count.
REQ-027 SHALL, with FIFO_SIMUL_RW_EN defined, on wr_en=rd_en=1 at data_count=0 perform write only (WRITE), and at data_count=DEPTH perform read only (READ).

Structure
REQ-028 SHALL take state encodings and DEPTH default from shared package fifo_pkg, also used by the output-logic stage.
REQ-029 SHALL split combinational next-state/next-count logic into sub-module fifo_ns; fifo_ctrl holds registers and strobes.

Verification
REQ-030 SHALL cover reset: assert reset 2 cycles with wr_en=1 -> state=000, data_count=0, head=tail=0, we=0.
REQ-031 SHALL cover fill: 8 consecutive writes from empty -> states 001 x8, data_count 1..8, tail 1..7,0; 9th write -> state 011, count 8, we=0.
REQ-032 SHALL cover drain: 8 reads from full -> states 010 x8, count 7..0, head wraps to 0; 9th read -> state 100, re=0.
REQ-033 SHALL cover idle: wr_en=rd_en=0 at count 3 -> state 111, count 3, pointers unchanged.
REQ-034 SHALL cover simultaneous at count 4: without macro -> 111, count 4, we=re=0; with FIFO_SIMUL_RW_EN -> 111, count 4, we=re=1, head and tail each +1.
REQ-035 SHALL cover reset mid-fill at count 5 -> next cycle state=000, count 0, head=tail=0.
